// File: rtl/set_bit_index_serializer.sv
// ============================================================================
// Module   : set_bit_index_serializer
// Purpose  : Streams the index of every set bit of a captured word, lowest
//            first, one index per valid/ready beat.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module set_bit_index_serializer #(
  parameter int W  = 16,
  parameter int IW = $clog2(W),
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_index,
  output logic          out_last,
  output logic          out_empty,
  output logic [CW-1:0] out_count,
  output logic          out_onehot
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [W-1:0] c_one = W'(1);

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_mask;
  logic [CW-1:0] r_count;
  logic          r_onehot;
  logic          r_empty;
  logic [CW-1:0] w_pop;
  logic          w_single;
  logic          w_accept;
  logic          w_beat;

  // Population count of the incoming word, only consumed on the accept edge.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < W; i++) begin
      w_pop = w_pop + CW'(in_data[i]);
    end
  end

  // Lowest set bit wins: scan downward so the last hit is the smallest index.
  always_comb begin
    out_index = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (r_mask[i]) out_index = IW'(i);
    end
  end

  assign w_single   = (r_mask != '0) && ((r_mask & (r_mask - c_one)) == '0);
  assign out_last   = w_single || r_empty;
  assign out_empty  = r_empty;
  assign out_count  = r_count;
  assign out_onehot = r_onehot;
  assign w_accept   = in_valid && in_ready;
  assign w_beat     = out_valid && out_ready;

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = !reset;
        if (in_valid && !reset) w_next = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready && out_last) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_mask   <= '0;
      r_count  <= '0;
      r_onehot <= 1'b0;
      r_empty  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mask   <= in_data;
        r_count  <= w_pop;
        r_onehot <= (w_pop == CW'(1));
        r_empty  <= (in_data == '0);
      end else if (w_beat) begin
        r_mask <= r_mask & (r_mask - c_one);
        if (out_last) r_empty <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_set_bit_index_serializer.sv
// ============================================================================
// Module   : tb_set_bit_index_serializer
// Purpose  : Directed bench with a queue-based beat model checked every cycle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_set_bit_index_serializer;

  localparam int W  = 16;
  localparam int IW = $clog2(W);
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          out_empty;
  logic [CW-1:0] out_count;
  logic          out_onehot;

  set_bit_index_serializer #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_last(out_last), .out_empty(out_empty), .out_count(out_count),
    .out_onehot(out_onehot)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit last;
    bit empty;
    int count;
    bit onehot;
  } beat_t;

  beat_t mq[$];
  int    log_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a word expands to its list of set-bit indices; popped on handshake.
  always @(posedge clk) begin
    if (!reset && out_valid && out_ready) log_q.push_back(int'(out_index));
    if (reset) begin
      mq.delete();
    end else if (mq.size() == 0) begin
      if (in_valid) begin
        int n;
        n = $countones(in_data);
        if (n == 0) begin
          mq.push_back('{idx: 0, last: 1'b1, empty: 1'b1, count: 0, onehot: 1'b0});
        end else begin
          for (int i = 0; i < W; i++) begin
            if (in_data[i]) mq.push_back('{idx: i, last: 1'b0, empty: 1'b0, count: n, onehot: (n == 1)});
          end
          mq[mq.size()-1].last = 1'b1;
        end
      end
    end else if (out_ready) begin
      void'(mq.pop_front());
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", in_ready, (!reset && mq.size() == 0));
      chk("out_valid", out_valid, (mq.size() != 0));
      if (out_valid && mq.size() != 0) begin
        chk("out_index", out_index, mq[0].idx);
        chk("out_last", out_last, mq[0].last);
        chk("out_empty", out_empty, mq[0].empty);
        chk("out_count", out_count, mq[0].count);
        chk("out_onehot", out_onehot, mq[0].onehot);
      end
    end
  end

  task automatic send(input logic [W-1:0] word);
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("send_timeout", ok, 1);
    #1 in_valid = 1'b1;
    in_data = word;
    @(negedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!out_valid && in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_timeout", ok, 1);
    #1;
  endtask

  initial begin
    int exp1[9];
    bit bad;
    exp1 = '{0, 1, 2, 4, 5, 7, 10, 11, 13};

    repeat (2) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_empty", out_empty, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_onehot", out_onehot, 0);
    #1 reset = 1'b0;

    // Sparse word with the model checking timing and fields every cycle.
    log_q.delete();
    send(16'b0010110010110111);
    drain();
    chk("w1_beats", log_q.size(), 9);
    for (int i = 0; i < 9 && i < log_q.size(); i++) chk("w1_index", log_q[i], exp1[i]);

    // Zero word gives a single beat flagged empty.
    log_q.delete();
    send(16'h0000);
    chk("zero_empty", out_empty, 1);
    chk("zero_last", out_last, 1);
    chk("zero_count", out_count, 0);
    drain();
    chk("zero_beats", log_q.size(), 1);

    log_q.delete();
    send(16'hFFFF);
    chk("full_count", out_count, 16);
    drain();
    chk("full_beats", log_q.size(), 16);
    if (log_q.size() == 16) chk("full_top", log_q[15], 15);

    log_q.delete();
    send(16'h0400);
    chk("oh_index", out_index, 10);
    chk("oh_onehot", out_onehot, 1);
    chk("oh_last", out_last, 1);
    drain();
    send(16'h0900);
    chk("two_onehot", out_onehot, 0);
    drain();
    chk("oh_beats", log_q.size(), 3);

    // Backpressure with in_data churning during EMIT.
    log_q.delete();
    out_ready = 1'b0;
    send(16'h8001);
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_index", out_index, 0);
      in_data = 16'($urandom);
      @(negedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_next_index", out_index, 15);
    chk("bp_next_last", out_last, 1);
    drain();
    chk("bp_beats", log_q.size(), 2);

    // Reset after the first beat of 0x00F0 has been taken.
    log_q.delete();
    send(16'h00F0);
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    #1 reset = 1'b0;
    bad = 1'b0;
    foreach (log_q[i]) if (log_q[i] >= 5 && log_q[i] <= 7) bad = 1'b1;
    chk("mid_rst_no_more", bad, 0);
    chk("mid_rst_beats", log_q.size(), 1);
    log_q.delete();
    send(16'h0002);
    chk("post_rst_index", out_index, 1);
    chk("post_rst_count", out_count, 1);
    drain();
    chk("post_rst_beats", log_q.size(), 1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
